// File: rtl/wishbone_arbiter_if.sv
// Wishbone bus bundle for the Argon two-master arbiter.
// The master modport is held by a bus initiator and the slave modport by the responder.
`timescale 1ns/1ps
interface wishbone_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH/8-1:0] sel;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic                    ack;
    logic                    err;

    // A request (cyc/stb with its payload) is held until ack or err terminates it.
    modport master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack, err);
    modport slave  (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);
endinterface

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter that lets the fetch master (m0) and the LSU master (m1) share one slave port.
// Define ARGON_ARB_TIMEOUT_EN to add a watchdog that aborts transfers the slave never acknowledges.
`timescale 1ns/1ps
module wishbone_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    wishbone_arbiter_if.slave    m0,
    wishbone_arbiter_if.slave    m1,
    wishbone_arbiter_if.master   s,
    output logic [1:0]           o_grant
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_M0 = 2'd1,
        GNT_M1 = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last;
    logic [1:0]            r_grant;
    logic                  w_timeout;
    logic                  w_pick_m1;
    logic                  w_cyc;
    logic                  w_stb;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_adr;
    logic [DATA_WIDTH-1:0] w_dat_w;
    logic [SEL_WIDTH-1:0]  w_sel;

`ifdef ARGON_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_stall;
    logic             w_leave;

    always_comb begin
        w_stall = 1'b0;
        w_leave = 1'b0;
        case (r_state)
            GNT_M0: begin
                w_stall = m0.stb & ~s.ack & ~s.err;
                w_leave = ~m0.cyc;
            end
            GNT_M1: begin
                w_stall = m1.stb & ~s.ack & ~s.err;
                w_leave = ~m1.cyc;
            end
            default: ;
        endcase
    end

    // The last stalled cycle itself raises the error, so compare against one less than the limit.
    assign w_timeout = w_stall & (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_stall && !w_timeout && !w_leave) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end
`else
    // Watchdog compiled out: never fires.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // On a tie the master that did not own the bus last wins.
    assign w_pick_m1 = m1.cyc & (~m0.cyc | ~r_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= 1'b0;
            r_grant <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_m1) begin
                        r_state <= GNT_M1;
                        r_last  <= 1'b1;
                        r_grant <= 2'b10;
                    end else if (m0.cyc) begin
                        r_state <= GNT_M0;
                        r_last  <= 1'b0;
                        r_grant <= 2'b01;
                    end
                end
                GNT_M0: begin
                    if (w_timeout) begin
                        r_state <= IDLE;
                        r_grant <= 2'b00;
                    end else if (!m0.cyc) begin
                        if (m1.cyc) begin
                            r_state <= GNT_M1;
                            r_last  <= 1'b1;
                            r_grant <= 2'b10;
                        end else begin
                            r_state <= IDLE;
                            r_grant <= 2'b00;
                        end
                    end
                end
                GNT_M1: begin
                    if (w_timeout) begin
                        r_state <= IDLE;
                        r_grant <= 2'b00;
                    end else if (!m1.cyc) begin
                        if (m0.cyc) begin
                            r_state <= GNT_M0;
                            r_last  <= 1'b0;
                            r_grant <= 2'b01;
                        end else begin
                            r_state <= IDLE;
                            r_grant <= 2'b00;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    assign o_grant = r_grant;

    always_comb begin
        w_cyc   = 1'b0;
        w_stb   = 1'b0;
        w_we    = 1'b0;
        w_adr   = '0;
        w_dat_w = '0;
        w_sel   = '0;
        case (r_state)
            GNT_M0: begin
                w_cyc   = m0.cyc;
                w_stb   = m0.stb;
                w_we    = m0.we;
                w_adr   = m0.adr;
                w_dat_w = m0.dat_w;
                w_sel   = m0.sel;
            end
            GNT_M1: begin
                w_cyc   = m1.cyc;
                w_stb   = m1.stb;
                w_we    = m1.we;
                w_adr   = m1.adr;
                w_dat_w = m1.dat_w;
                w_sel   = m1.sel;
            end
            default: ;
        endcase
        if (w_timeout) begin
            w_cyc = 1'b0;
            w_stb = 1'b0;
        end
    end

    assign s.cyc   = w_cyc;
    assign s.stb   = w_stb;
    assign s.we    = w_we;
    assign s.adr   = w_adr;
    assign s.dat_w = w_dat_w;
    assign s.sel   = w_sel;

    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;
    assign m0.ack   = (r_state == GNT_M0) & s.ack;
    assign m1.ack   = (r_state == GNT_M1) & s.ack;
    assign m0.err   = (r_state == GNT_M0) & (s.err | w_timeout);
    assign m1.err   = (r_state == GNT_M1) & (s.err | w_timeout);
endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter: bus-master driver tasks, a simple slave responder,
// and a termination scoreboard that pops one expected entry per ack/err seen on either master.
`timescale 1ns/1ps
module tb_wishbone_arbiter;
  localparam logic [31:0] RD_DATA = 32'hDEADBEEF;
  localparam int W = 68;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] o_grant;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  int   slave_lat = 2;
  logic slave_err_mode = 1'b0;
  int   wait_cnt = 0;
  int   n;

  logic [3:0]   mon_term;
  logic [W-1:0] mon_act;
  logic [W-1:0] mon_exp;

  wishbone_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_bus();
  wishbone_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_bus();
  wishbone_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_bus();

  wishbone_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .m0(m0_bus),
    .m1(m1_bus),
    .s(s_bus),
    .o_grant(o_grant)
  );

  // ---------------- clock / reset-independent watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench did not finish");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Expected termination: {m1_err, m1_ack, m0_err, m0_ack, m1_dat_r, m0_dat_r}.
  task automatic exp_push(input int m, input logic is_err);
    logic [3:0] t;
    t = 4'b0000;
    if (m == 0) t = is_err ? 4'b0010 : 4'b0001;
    else        t = is_err ? 4'b1000 : 4'b0100;
    exp_q.push_back({t, RD_DATA, RD_DATA});
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (m == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
      m0_bus.adr = adr; m0_bus.dat_w = dat; m0_bus.sel = sel;
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
      m1_bus.adr = adr; m1_bus.dat_w = dat; m1_bus.sel = sel;
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after a rising edge with cyc low for one cycle.
  task automatic master_xfer(input int m, input logic we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
    logic done;
    drive_m(m, 1'b1, 1'b1, we, adr, dat, sel);
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (m == 0) ? (m0_bus.ack | m0_bus.err) : (m1_bus.ack | m1_bus.err);
    end
    chk($sformatf("xfer_done_m%0d", m), done, 1'b1);
    @(posedge clk); #1;
    drive_m(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
  endtask

  // ---------------- slave responder ----------------
  initial begin
    s_bus.ack = 1'b0;
    s_bus.err = 1'b0;
    s_bus.dat_r = RD_DATA;
    forever begin
      @(posedge clk); #2;
      if (s_bus.ack || s_bus.err) begin
        s_bus.ack = 1'b0;
        s_bus.err = 1'b0;
        wait_cnt = 0;
      end else if (s_bus.cyc && s_bus.stb && slave_lat >= 0) begin
        if (wait_cnt >= slave_lat) begin
          s_bus.ack = !slave_err_mode;
          s_bus.err = slave_err_mode;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      mon_term = {m1_bus.err, m1_bus.ack, m0_bus.err, m0_bus.ack};
      if (mon_term != 4'b0000) begin
        checks++;
        mon_act = {mon_term, m1_bus.dat_r, m0_bus.dat_r};
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_term act=%h exp=none", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            failures++;
            $display("FAIL term act=%h exp=%h", mon_act, mon_exp);
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_cyc", s_bus.cyc, 1'b0);
    chk("rst_s_stb", s_bus.stb, 1'b0);
    chk("rst_s_adr", s_bus.adr, 32'h0);
    chk("rst_grant", o_grant, 2'b00);
    chk("rst_acks", {m1_bus.err, m1_bus.ack, m0_bus.err, m0_bus.ack}, 4'b0000);
    chk("rst_dat_r", {m1_bus.dat_r, m0_bus.dat_r}, {RD_DATA, RD_DATA});
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Single master read, slave acks two cycles after strobe.
    slave_lat = 2;
    exp_push(0, 1'b0);
    fork
      master_xfer(0, 1'b0, 32'h0000_0100, 32'h0, 4'hf);
      begin
        int mis;
        mis = 0;
        @(posedge clk); @(negedge clk);
        chk("single_grant", o_grant, 2'b01);
        chk("single_s_adr", s_bus.adr, 32'h0000_0100);
        repeat (5) begin
          @(negedge clk);
          if (m0_bus.ack !== s_bus.ack || m1_bus.ack !== 1'b0) mis++;
        end
        chk("single_ack_align", mis, 0);
      end
    join
    @(posedge clk); #1;

    // Tie after reset: M1 first, then direct handoff to M0.
    slave_lat = 1;
    exp_push(1, 1'b0);
    exp_push(0, 1'b0);
    fork
      master_xfer(1, 1'b1, 32'h8000_0000, 32'h1234_5678, 4'hf);
      master_xfer(0, 1'b0, 32'h0000_0104, 32'h0, 4'hf);
      begin
        @(posedge clk); @(negedge clk);
        chk("tie_grant", o_grant, 2'b10);
        chk("tie_s_bus", {s_bus.cyc, s_bus.we, s_bus.sel, s_bus.adr, s_bus.dat_w},
            {1'b1, 1'b1, 4'hf, 32'h8000_0000, 32'h1234_5678});
        n = 0;
        while (m1_bus.cyc && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("tie_m1_released", m1_bus.cyc, 1'b0);
        chk("tie_grant_held", o_grant, 2'b10);
        @(negedge clk);
        chk("tie_handoff", o_grant, 2'b01);
      end
    join
    @(posedge clk); #1;

    // Round-robin: both keep re-requesting, ten transfers alternating M1, M0, ...
    slave_lat = 1;
    for (int i = 0; i < 10; i++) exp_push((i % 2 == 0) ? 1 : 0, 1'b0);
    fork
      begin repeat (5) master_xfer(1, 1'b0, 32'h0000_0200, 32'h0, 4'hf); end
      begin repeat (5) master_xfer(0, 1'b0, 32'h0000_0300, 32'h0, 4'hf); end
    join

    // Slave error on an M1 read.
    slave_err_mode = 1'b1;
    exp_push(1, 1'b1);
    master_xfer(1, 1'b0, 32'h0000_0400, 32'h0, 4'hf);
    slave_err_mode = 1'b0;

    // Reset in the middle of an M1 transfer.
    slave_lat = -1;
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0440, 32'h0, 4'hf);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_pre_grant", o_grant, 2'b10);
    chk("midrst_pre_stb", {s_bus.cyc, s_bus.stb}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("midrst_s_cyc", {s_bus.cyc, s_bus.stb}, 2'b00);
    chk("midrst_grant", o_grant, 2'b00);
    chk("midrst_m1_ack", {m1_bus.err, m1_bus.ack}, 2'b00);
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    slave_lat = 1;
    exp_push(1, 1'b0);
    exp_push(0, 1'b0);
    fork
      master_xfer(1, 1'b0, 32'h0000_0480, 32'h0, 4'hf);
      master_xfer(0, 1'b0, 32'h0000_04c0, 32'h0, 4'hf);
      begin
        @(posedge clk); @(negedge clk);
        chk("postrst_tie_grant", o_grant, 2'b10);
      end
    join
    @(posedge clk); #1;

    // Slave that never acknowledges an M0 request.
    slave_lat = -1;
`ifdef ARGON_ARB_TIMEOUT_EN
    exp_push(0, 1'b1);
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hf);
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("to_m0_err_c%0d", k), m0_bus.err, (k == 8));
      chk($sformatf("to_s_cyc_c%0d", k), s_bus.cyc, (k != 8));
      if (k == 3) drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hf);
    end
    @(posedge clk); #1;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("to_idle", o_grant, 2'b00);
    @(negedge clk);
    chk("to_m1_grant", o_grant, 2'b10);
    @(posedge clk); #1;
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
`else
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hf);
    n = 0;
    repeat (1000) begin
      @(negedge clk);
      if (m0_bus.err) n++;
    end
    chk("no_timeout_err", n, 0);
    chk("hang_grant", o_grant, 2'b01);
    chk("hang_s_cyc", s_bus.cyc, 1'b1);
    @(posedge clk); #1;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
`endif
    slave_lat = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wishbone_arbiter.md
# wishbone_arbiter

Two-master, one-slave Wishbone arbiter for the Argon core. It shares a single memory port between the instruction-fetch master (M0) and the load/store-unit master (M1), so the CPU's two bus masters can sit behind one unified memory or interconnect port. Arbitration is round-robin, and a grant is held for the owner's whole `cyc` cycle. An optional watchdog aborts transfers that the slave never acknowledges.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width of all ports.
- `DATA_WIDTH`, 32, data width; `SEL_WIDTH` = `DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, 255, watchdog limit in cycles (≥2); used only with `ARGON_ARB_TIMEOUT_EN`.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `m0_cyc`, `m0_stb`, `m0_we`  in  1 each  M0 (instruction fetch) request qualifiers.
- `m0_adr`  in  ADDR_WIDTH  M0 address.
- `m0_dat_w`  in  DATA_WIDTH  M0 write data.
- `m0_sel`  in  SEL_WIDTH  M0 byte selects.
- `m0_dat_r`  out  DATA_WIDTH  read data to M0.
- `m0_ack`, `m0_err`  out  1 each  termination to M0.
- `m1_*`: identical set for M1 (LSU).
- `s_cyc`, `s_stb`, `s_we`  out  1 each  request to slave.
- `s_adr`  out  ADDR_WIDTH  slave address.
- `s_dat_w`  out  DATA_WIDTH  slave write data.
- `s_sel`  out  SEL_WIDTH  slave byte selects.
- `s_dat_r`  in  DATA_WIDTH  slave read data.
- `s_ack`, `s_err`  in  1 each  slave termination.
- `o_grant`  out  2  one-hot owner: `01` = M0, `10` = M1, `00` = idle.

## Operation
- **State machine:** states IDLE, GNT_M0, GNT_M1. Register `last` holds the most recent owner; it resets to M0.
- **From IDLE:**
  - Only one of `mX_cyc` high: go to GNT_X.
  - Both high: go to the master that is not `last`, so M1 wins the first tie after reset.
- **While in GNT_X:**
  - Owner drops `cyc`, other master's `cyc` is low: go to IDLE.
  - Owner drops `cyc`, other master's `cyc` is high: go directly to GNT_other (no IDLE bubble).
  - `last` updates to X on entry to GNT_X.
- **Routing:**
  - Slave outputs are combinationally muxed from the owner.
  - In IDLE, all slave outputs are 0.
  - `s_dat_r` is broadcast to both `mX_dat_r`.
  - `s_ack` and `s_err` are routed only to the owner; the non-owner sees 0.
- **Wait state:** a non-owner with `cyc` high simply waits. It receives no ack, so it sees ordinary wait states.
- **Reset:** async assertion forces IDLE and `last` = M0 immediately. `s_cyc`/`s_stb` drop combinationally, including mid-transfer. Any in-flight transaction is abandoned, with no ack or err delivered.

## Timing
- **Reset values:** `s_*` outputs 0, `mX_ack`/`mX_err` 0, `o_grant` 00, `mX_dat_r` = `s_dat_r`.
- **Grant latency:** request seen at edge N gives `o_grant` and `s_cyc` valid after edge N+1. This is one cycle of arbitration latency from IDLE, or from a handoff.
- **Ack path:** `s_ack` to `mX_ack` is combinational, zero cycles.
- **Pipelining:** back-to-back strobes within one `cyc` are passed through with no added cycles.
- **Simultaneous owner release and other request:** handoff completes at the next edge.
- **Owner drops and re-raises `cyc` in adjacent cycles:** this counts as a new request and is arbitrated against the other master.

## Configuration
- **`ARGON_ARB_TIMEOUT_EN` defined:**
  - A counter (`$clog2(TIMEOUT_CYCLES+1)` bits) increments each cycle in GNT_X with `s_stb`=1 and `s_ack`=`s_err`=0.
  - The counter clears on ack, on err, on strobe low, and on grant change.
  - When the count reaches `TIMEOUT_CYCLES`, `mX_err` pulses for one cycle and `s_cyc`/`s_stb` are forced to 0 that cycle.
  - State then goes to IDLE, with `last` = X so the other master gets priority.
- **Not defined:** no counter and no timeout. `mX_err` reflects only routed `s_err`, and a missing ack hangs the owner indefinitely.

## Test plan
- **Single master:** M0 reads 0x0000_0100 with the slave acking 2 cycles after `s_stb`. Required: `o_grant`=01 one cycle after `m0_cyc`, `m0_ack` aligned with `s_ack`, `m0_dat_r` = 0xDEADBEEF, M1 sees `m1_ack`=0 throughout.
- **Tie after reset:** M0 and M1 raise `cyc` in the same cycle. Required: M1 granted first (`o_grant`=10), M1 write of 0x1234_5678 to 0x8000_0000 with `sel`=1111 appears on `s_*`, then a direct handoff to M0 the cycle after `m1_cyc` drops, with no IDLE cycle.
- **Round-robin fairness:** both masters continuously re-request for 10 transfers. Required: grants strictly alternate M1, M0, M1, …
- **Reset mid-transfer:** assert `reset` while in GNT_M1 with `s_stb`=1. Required: `s_cyc`=0 and `o_grant`=00 asynchronously, no `m1_ack`, and after release M0 idle with a tie goes to M1.
- **Timeout, macro defined:** `TIMEOUT_CYCLES`=8, slave never acks an M0 request. Required: `m0_err`=1 for exactly one cycle at the 8th stalled cycle, `s_cyc`=0 that cycle, then IDLE, then M1 granted if requesting. Macro undefined: `m0_err` stays 0 for 1000 cycles.
- **Slave error passthrough:** slave returns `s_err` on an M1 read. Required: `m1_err`=1 in the same cycle, `m0_err`=0.
